// File: rtl/jpeg_rle_pkg.sv
// jpeg_rle_pkg: shared types and constants for the JPEG run-length encoder.
//   state_t    : encoder FSM states
//   sym_t      : (run, size, amp) symbol fields
//   marker_sym : builds the fixed ZRL (15,0,0) and EOB (0,0,0) symbols
package jpeg_rle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC,
    S_SCAN,
    S_ZRL,
    S_EOB
  } state_t;

  localparam int unsigned SIZE_W  = 4;
  localparam int unsigned AMP_W   = 11;
  localparam int          ZRL_RUN = 15;
  localparam int          AC_MAX  = 1023;
  localparam int          DC_MAX  = 2047;

  typedef struct packed {
    logic [3:0]        run;
    logic [SIZE_W-1:0] size;
    logic [AMP_W-1:0]  amp;
  } sym_t;

  // is_zrl=1 gives ZRL (15,0,0); is_zrl=0 gives EOB (0,0,0).
  function automatic sym_t marker_sym(input logic is_zrl);
    sym_t s;
    s = '0;
    if (is_zrl) s.run = 4'(ZRL_RUN);
    return s;
  endfunction

endpackage

// File: rtl/jpeg_rle_category.sv
// jpeg_rle_category: combinational JPEG magnitude category.
//   val  : signed 12-bit integer (expected within +/-2047)
//   size : bit length of |val|, 0 for val == 0
//   amp  : val for val > 0, low size bits of (val-1) for val < 0, zero above size
module jpeg_rle_category
  import jpeg_rle_pkg::*;
(
  input  logic signed [11:0]       val,
  output logic        [SIZE_W-1:0] size,
  output logic        [AMP_W-1:0]  amp
);

  logic [10:0] mag;
  logic [10:0] mask;

  always_comb begin
    mag  = val[11] ? 11'(-val) : val[10:0];
    size = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      if (mag[i]) size = SIZE_W'(i + 1);
    end
    mask = 11'((12'd1 << size) - 12'd1);
    amp  = val[11] ? (11'(val - 12'sd1) & mask) : val[10:0];
  end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder: captures one zigzag-ordered block of fixed-point
// coefficients, rounds them to integers, DC-differences against a predictor
// and emits JPEG (run, size, amp) symbols including ZRL and EOB.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   coef_in, block_valid  : block input (word k at [k*DATA_WIDTH +: DATA_WIDTH])
//   block_ready           : high in IDLE
//   dc_clear              : clears the DC predictor while in IDLE
//   sym_valid/sym_ready   : symbol handshake
//   sym_run/size/amp      : symbol fields; sym_is_dc / sym_last flags
module jpeg_rle_encoder
  import jpeg_rle_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] coef_in,
  input  logic                              block_valid,
  output logic                              block_ready,
  input  logic                              dc_clear,
  output logic                              sym_valid,
  input  logic                              sym_ready,
  output logic [3:0]                        sym_run,
  output logic [SIZE_W-1:0]                 sym_size,
  output logic [AMP_W-1:0]                  sym_amp,
  output logic                              sym_is_dc,
  output logic                              sym_last
);

  localparam int SUM_W = DATA_WIDTH + 1;

  // Round half up, arithmetic shift, clamp to +/-lim.
  function automatic logic signed [11:0] to_int(input logic [DATA_WIDTH-1:0] w,
                                                input int lim);
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    s  = $signed({w[DATA_WIDTH-1], w}) + $signed(SUM_W'(1) << (FRAC_BITS - 1));
    s  = s >>> FRAC_BITS;
    hi = SUM_W'(lim);
    lo = -hi;
    if (s > hi)      return hi[11:0];
    else if (s < lo) return lo[11:0];
    else             return s[11:0];
  endfunction

  logic [DATA_WIDTH-1:0] coef_q [PIXEL_COUNT];
  logic [DATA_WIDTH-1:0] coef_d [PIXEL_COUNT];
  state_t                state_q, state_d;
  logic signed [11:0]    pred_q, pred_d;
  logic [5:0]            run_q, run_d;
  logic [6:0]            k_q, k_d;
  logic                  sym_valid_q, sym_valid_d;
  sym_t                  sym_q, sym_d;
  logic                  is_dc_q, is_dc_d;
  logic                  last_q, last_d;

  logic signed [11:0]    dc_int, pred_eff, dc_diff, ac_val, cat_val;
  logic signed [12:0]    diff_full;
  logic [SIZE_W-1:0]     cat_size;
  logic [AMP_W-1:0]      cat_amp;
  logic                  advance;

  assign block_ready = (state_q == S_IDLE) && !reset;
  assign sym_valid   = sym_valid_q;
  assign sym_run     = sym_q.run;
  assign sym_size    = sym_q.size;
  assign sym_amp     = sym_q.amp;
  assign sym_is_dc   = is_dc_q;
  assign sym_last    = last_q;

  always_comb begin
    dc_int    = to_int(coef_in[0 +: DATA_WIDTH], DC_MAX);
    pred_eff  = dc_clear ? '0 : pred_q;
    diff_full = 13'(dc_int) - 13'(pred_eff);
    if (diff_full > 13'(DC_MAX))       dc_diff = 12'(DC_MAX);
    else if (diff_full < -13'(DC_MAX)) dc_diff = -12'(DC_MAX);
    else                               dc_diff = diff_full[11:0];
    ac_val  = to_int(coef_q[k_q[5:0]], AC_MAX);
    // One category unit: DC difference while idle, current AC otherwise.
    cat_val = (state_q == S_IDLE) ? dc_diff : ac_val;
  end

  jpeg_rle_category u_category (
    .val  (cat_val),
    .size (cat_size),
    .amp  (cat_amp)
  );

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    run_d       = run_q;
    k_d         = k_q;
    sym_valid_d = sym_valid_q;
    sym_d       = sym_q;
    is_dc_d     = is_dc_q;
    last_d      = last_q;
    coef_d      = coef_q;
    // Output slot is free, or its symbol is taken on this edge.
    advance     = !sym_valid_q || sym_ready;

    unique case (state_q)
      S_IDLE: begin
        if (dc_clear) pred_d = '0;
        if (block_valid && block_ready) begin
          for (int unsigned i = 0; i < PIXEL_COUNT; i++) begin
            coef_d[i] = coef_in[i*DATA_WIDTH +: DATA_WIDTH];
          end
          pred_d      = dc_int;
          run_d       = '0;
          k_d         = 7'd1;
          sym_valid_d = 1'b1;
          sym_d       = '{run: '0, size: cat_size, amp: cat_amp};
          is_dc_d     = 1'b1;
          last_d      = 1'b0;
          state_d     = S_DC;
        end
      end
      S_DC: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (advance) begin
          sym_valid_d = 1'b0;
          is_dc_d     = 1'b0;
          last_d      = 1'b0;
          if (k_q == 7'd64) begin
            // The k=63 symbol carried sym_last and has just been accepted.
            state_d = S_IDLE;
          end else if (ac_val == '0) begin
            run_d = run_q + 6'd1;
            k_d   = k_q + 7'd1;
            if (k_q == 7'd63) begin
              sym_valid_d = 1'b1;
              sym_d       = marker_sym(1'b0);
              last_d      = 1'b1;
              state_d     = S_EOB;
            end
          end else if (run_q >= 6'd16) begin
            sym_valid_d = 1'b1;
            sym_d       = marker_sym(1'b1);
            run_d       = run_q - 6'd16;
            state_d     = S_ZRL;
          end else begin
            sym_valid_d = 1'b1;
            sym_d       = '{run: run_q[3:0], size: cat_size, amp: cat_amp};
            last_d      = (k_q == 7'd63);
            run_d       = '0;
            k_d         = k_q + 7'd1;
          end
        end
      end
      S_ZRL: begin
        if (advance) begin
          sym_valid_d = 1'b1;
          if (run_q >= 6'd16) begin
            sym_d = marker_sym(1'b1);
            run_d = run_q - 6'd16;
          end else begin
            sym_d   = '{run: run_q[3:0], size: cat_size, amp: cat_amp};
            last_d  = (k_q == 7'd63);
            run_d   = '0;
            k_d     = k_q + 7'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_EOB: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pred_q      <= '0;
      run_q       <= '0;
      k_q         <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      is_dc_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      run_q       <= run_d;
      k_q         <= k_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      is_dc_q     <= is_dc_d;
      last_q      <= last_d;
    end
  end

  // Block storage is only meaningful after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    coef_q <= coef_d;
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
module tb_jpeg_rle_encoder;

  localparam int DW   = 32;
  localparam int NPIX = 64;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [DW*NPIX-1:0] coef_in = '0;
  logic               block_valid = 1'b0;
  logic               block_ready;
  logic               dc_clear = 1'b0;
  logic               sym_valid;
  logic               sym_ready = 1'b1;
  logic [3:0]         sym_run;
  logic [3:0]         sym_size;
  logic [10:0]        sym_amp;
  logic               sym_is_dc;
  logic               sym_last;
  logic [20:0]        obs_sym;

  int          checks = 0;
  int          failures = 0;
  int          nsym = 0;
  int          pred_m = 0;
  logic [20:0] sb_q[$];
  logic [31:0] blk [NPIX];

  always #5 clk = ~clk;

  assign obs_sym = {sym_is_dc, sym_last, sym_run, sym_size, sym_amp};

  jpeg_rle_encoder #(.DATA_WIDTH(DW), .FRAC_BITS(16), .PIXEL_COUNT(NPIX)) dut (
    .clk         (clk),
    .reset       (reset),
    .coef_in     (coef_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .dc_clear    (dc_clear),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_run     (sym_run),
    .sym_size    (sym_size),
    .sym_amp     (sym_amp),
    .sym_is_dc   (sym_is_dc),
    .sym_last    (sym_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: round half up, clamp to +/-lim.
  function automatic int conv(input logic [31:0] w, input int lim);
    longint v;
    v = (longint'($signed(w)) + 64'sd32768) >>> 16;
    if (v > lim)  v = lim;
    if (v < -lim) v = -lim;
    return int'(v);
  endfunction

  // Packed symbol {is_dc, last, run, size, amp}.
  function automatic logic [20:0] mk(input bit dc, input bit last, input int run, input int v);
    int m, sz, amp;
    m  = (v < 0) ? -v : v;
    sz = 0;
    while (m != 0) begin
      sz++;
      m = m >> 1;
    end
    amp = (v >= 0) ? v : ((v - 1) & ((1 << sz) - 1));
    return {dc, last, run[3:0], sz[3:0], amp[10:0]};
  endfunction

  task automatic model_push(input bit clr);
    int dc, diff, run, v;
    if (clr) pred_m = 0;
    dc   = conv(blk[0], 2047);
    diff = dc - pred_m;
    if (diff > 2047)  diff = 2047;
    if (diff < -2047) diff = -2047;
    sb_q.push_back(mk(1'b1, 1'b0, 0, diff));
    pred_m = dc;
    run = 0;
    for (int k = 1; k < NPIX; k++) begin
      v = conv(blk[k], 1023);
      if (v == 0) run++;
      else begin
        while (run >= 16) begin
          sb_q.push_back(mk(1'b0, 1'b0, 15, 0));
          run -= 16;
        end
        sb_q.push_back(mk(1'b0, k == 63, run, v));
        run = 0;
      end
    end
    if (run > 0) sb_q.push_back(mk(1'b0, 1'b1, 0, 0));
  endtask

  task automatic clear_blk();
    for (int k = 0; k < NPIX; k++) blk[k] = '0;
  endtask

  task automatic send_block(input bit clr);
    @(posedge clk); #1;
    for (int k = 0; k < NPIX; k++) coef_in[k*DW +: DW] = blk[k];
    block_valid = 1'b1;
    dc_clear    = clr;
    model_push(clr);
    @(posedge clk); #1;
    block_valid = 1'b0;
    dc_clear    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (block_ready && sb_q.size() == 0) done = 1'b1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every accepted symbol is popped against the model queue.
  always @(negedge clk) begin
    if (!reset && sym_valid && sym_ready) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_symbol observed=%0h expected=none", obs_sym);
      end
      if (sb_q.size() != 0) begin
        chk("symbol", {11'd0, obs_sym}, {11'd0, sb_q[0]});
        void'(sb_q.pop_front());
      end
      nsym++;
    end
  end

  initial begin
    int cnt, n0;
    clear_blk();

    // Reset state
    repeat (2) @(negedge clk);
    chk("ready_in_reset", {31'd0, block_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, block_ready}, 32'd1);
    chk("valid_after_reset", {31'd0, sym_valid}, 32'd0);
    chk("fields_after_reset", {11'd0, obs_sym}, 32'd0);

    // 1: all-zero block, latency and symbol count
    n0 = nsym;
    send_block(1'b0);
    @(negedge clk);
    cnt = 1;
    chk("dc_latency_valid", {31'd0, sym_valid}, 32'd1);
    chk("dc_latency_flag", {31'd0, sym_is_dc}, 32'd1);
    while (!block_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("ready_return_cycles", cnt, 32'd66);
    chk("t1_symbols", nsym - n0, 32'd2);

    // 2: DC prediction sequence
    blk[0] = 32'd5 << 16;
    send_block(1'b0);
    wait_idle("t2a_idle");
    blk[0] = 32'd3 << 16;
    send_block(1'b0);
    wait_idle("t2b_idle");
    send_block(1'b1);
    wait_idle("t2c_idle");

    // 3: long run before a single -1.0
    clear_blk();
    blk[20] = 32'hFFFF_0000;
    send_block(1'b0);
    wait_idle("t3_idle");

    // 4: only the last coefficient nonzero
    clear_blk();
    blk[63] = 32'd7 << 16;
    n0 = nsym;
    send_block(1'b0);
    wait_idle("t4_idle");
    chk("t4_symbols", nsym - n0, 32'd5);

    // 5: backpressure for 10 cycles with a symbol pending
    clear_blk();
    for (int k = 1; k <= 10; k++) blk[k] = (k % 2 == 0) ? 32'(k << 16) : 32'(-(k << 16));
    n0 = nsym;
    send_block(1'b0);
    repeat (3) @(posedge clk);
    #1 sym_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, sym_valid}, 32'd1);
      chk("stall_hold", {11'd0, obs_sym}, {11'd0, sb_q[0]});
      chk("stall_block_ready", {31'd0, block_ready}, 32'd0);
    end
    @(posedge clk); #1;
    sym_ready = 1'b1;
    wait_idle("t5_idle");
    chk("t5_symbols", nsym - n0, 32'd12);

    // 6: clamping and rounding
    clear_blk();
    blk[0] = 32'd2047 << 16;
    blk[1] = 32'd5000 << 16;
    blk[2] = 32'h0000_8000;
    blk[3] = 32'hFFFF_8000;
    blk[4] = 32'(-(3000 << 16));
    send_block(1'b1);
    wait_idle("t6a_idle");
    blk[0] = 32'(-(2047 << 16));
    send_block(1'b0);
    wait_idle("t6b_idle");

    // Reset in the middle of a scan
    clear_blk();
    blk[0] = 32'd9 << 16;
    send_block(1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    reset  = 1'b0;
    pred_m = 0;
    @(negedge clk);
    chk("midreset_valid", {31'd0, sym_valid}, 32'd0);
    chk("midreset_ready", {31'd0, block_ready}, 32'd1);
    send_block(1'b0);
    wait_idle("post_reset_idle");

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
